// File: rtl/muldiv_if.sv
// Ready/valid request/response bundle between the EX stage and muldiv_unit.
// The master side drives operands, kill and out_ready; the unit is the slave.
interface muldiv_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     kill;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    Result;
    logic                     busy;

    modport master (
        output in_valid, Operation, SrcA, SrcB, kill, out_ready,
        input  in_ready, out_valid, Result, busy
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, kill, out_ready,
        output in_ready, out_valid, Result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle combinational one.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_n;

    logic [2:0]      op_r;
    logic [W-1:0]    opd_r;
    logic [2*W-1:0]  acc_r;
    logic            a_neg_r;
    logic            b_neg_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    result_r;
    logic            out_valid_r;
    logic            busy_r;

    logic [OPCODE_LENGTH-1:0] op_in_s;
    logic [2:0]      op_s;
    logic            signed_a_s;
    logic            signed_b_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [W-1:0]    mag_a_s;
    logic [W-1:0]    mag_b_s;
    logic            is_div_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            special_s;
    logic [W-1:0]    special_res_s;
    logic            fast_s;
    logic [W-1:0]    fast_res_s;
    logic            accept_s;
    logic            last_s;

    logic [W:0]      mul_sum_s;
    logic [2*W-1:0]  mul_step_s;
    logic [W:0]      rem_shift_s;
    logic [W-1:0]    div_diff_s;
    logic [2*W-1:0]  div_step_s;
    logic [2*W-1:0]  acc_next_s;
    logic [2*W-1:0]  prod_s;
    logic [W-1:0]    fix_res_s;

    function automatic logic [W-1:0] cond_neg(input logic neg, input logic [W-1:0] v);
        return neg ? (~v + W'(1)) : v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg2(input logic neg, input logic [2*W-1:0] v);
        return neg ? (~v + (2*W)'(1)) : v;
    endfunction

    assign op_in_s  = bus.Operation;
    assign accept_s = bus.in_valid && !bus.kill && (state_r == IDLE);
    assign last_s   = (cnt_r == CW'(W - 1));

    // Operand decode: signedness, magnitudes and the single-cycle special cases.
    always_comb begin
        op_s       = op_in_s[2:0];
        signed_a_s = (op_s == OP_MUL) || (op_s == OP_MULH) || (op_s == OP_MULHSU) ||
                     (op_s == OP_DIV) || (op_s == OP_REM);
        signed_b_s = (op_s == OP_MUL) || (op_s == OP_MULH) ||
                     (op_s == OP_DIV) || (op_s == OP_REM);
        a_neg_s    = signed_a_s && bus.SrcA[W-1];
        b_neg_s    = signed_b_s && bus.SrcB[W-1];
        mag_a_s    = cond_neg(a_neg_s, bus.SrcA);
        mag_b_s    = cond_neg(b_neg_s, bus.SrcB);
        is_div_s   = op_s[2];
        div_zero_s = is_div_s && (bus.SrcB == {W{1'b0}});
        ovf_s      = ((op_s == OP_DIV) || (op_s == OP_REM)) &&
                     (bus.SrcA == MOST_NEG) && (bus.SrcB == {W{1'b1}});
        special_s  = div_zero_s || ovf_s;
        // op bit 1 separates remainder (REM/REMU) from quotient (DIV/DIVU)
        if (div_zero_s) begin
            special_res_s = op_s[1] ? bus.SrcA : {W{1'b1}};
        end else if (ovf_s) begin
            special_res_s = op_s[1] ? {W{1'b0}} : bus.SrcA;
        end else begin
            special_res_s = {W{1'b0}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_prod_s;

    // Single-cycle multiply path; divides still take the iterative route.
    always_comb begin
        fast_s      = !op_s[2];
        fast_prod_s = cond_neg2(a_neg_s ^ b_neg_s,
                                {{W{1'b0}}, mag_a_s} * {{W{1'b0}}, mag_b_s});
        if (op_s == OP_MUL) begin
            fast_res_s = fast_prod_s[W-1:0];
        end else begin
            fast_res_s = fast_prod_s[2*W-1:W];
        end
    end
`else
    // No fast multiplier: every multiply iterates.
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = {W{1'b0}};
    end
`endif

    // One iteration of shift-add multiply or restoring divide, plus sign fix-up of its outcome.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + {1'b0, (acc_r[0] ? opd_r : {W{1'b0}})};
        mul_step_s  = {mul_sum_s, acc_r[W-1:1]};
        // partial remainder keeps one extra bit so a divisor with its MSB set still compares correctly
        rem_shift_s = acc_r[2*W-1:W-1];
        div_diff_s  = rem_shift_s[W-1:0] - opd_r;
        if (rem_shift_s >= {1'b0, opd_r}) begin
            div_step_s = {div_diff_s, acc_r[W-2:0], 1'b1};
        end else begin
            div_step_s = {rem_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
        end
        acc_next_s = op_r[2] ? div_step_s : mul_step_s;
        prod_s     = cond_neg2(a_neg_r ^ b_neg_r, acc_next_s);
        case (op_r)
            OP_MUL:    fix_res_s = prod_s[W-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fix_res_s = prod_s[2*W-1:W];
            OP_DIV:    fix_res_s = cond_neg(a_neg_r ^ b_neg_r, acc_next_s[W-1:0]);
            OP_DIVU:   fix_res_s = acc_next_s[W-1:0];
            OP_REM:    fix_res_s = cond_neg(a_neg_r, acc_next_s[2*W-1:W]);
            OP_REMU:   fix_res_s = acc_next_s[2*W-1:W];
            default:   fix_res_s = {W{1'b0}};
        endcase
    end

    // Next-state logic; kill overrides everything.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (special_s || fast_s) begin
                        state_n = DONE;
                    end else begin
                        state_n = CALC;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_n = IDLE;
                end else if (last_s) begin
                    state_n = DONE;
                end else begin
                    state_n = CALC;
                end
            end
            DONE: begin
                if (bus.kill || bus.out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Status outputs registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_n == DONE);
            busy_r      <= (state_n != IDLE);
        end
    end

    // Operand capture on accept, iteration while calculating, result load on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= 3'b000;
            opd_r    <= {W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            result_r <= {W{1'b0}};
        end else if (accept_s) begin
            op_r    <= op_s;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            cnt_r   <= {CW{1'b0}};
            if (is_div_s) begin
                opd_r <= mag_b_s;
                acc_r <= {{W{1'b0}}, mag_a_s};
            end else begin
                opd_r <= mag_a_s;
                acc_r <= {{W{1'b0}}, mag_b_s};
            end
            if (special_s) begin
                result_r <= special_res_s;
            end else if (fast_s) begin
                result_r <= fast_res_s;
            end else begin
                result_r <= result_r;
            end
        end else if ((state_r == CALC) && !bus.kill) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CW'(1);
            if (last_s) begin
                result_r <= fix_res_s;
            end else begin
                result_r <= result_r;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.Result    = result_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; latency expectations follow MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic seen;

    muldiv_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) bus ();

    muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    // Latency counts the accepting edge as edge 1.
    task automatic wait_out(input string tag, input int lat, input logic [31:0] exp);
        int n = 1;
        while ((bus.out_valid !== 1'b1) && (n <= 60)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_result"}, bus.Result, exp);
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_after_take"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_ready_after_take"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] exp);
        issue(tag, op, a, b);
        wait_out(tag, lat, exp);
        take(tag);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.Operation = 3'b000;
        bus.SrcA      = 32'd0;
        bus.SrcB      = 32'd0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;

        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result",    bus.Result,             32'd0);
        chk("rst_busy",      {31'd0, bus.busy},      32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run("mul_7_m3",     MUL,    32'd7,          32'hFFFF_FFFD, MUL_LAT, 32'hFFFF_FFEB);
        run("mul_low",      MUL,    32'h0001_0001,  32'h0001_0001, MUL_LAT, 32'h0002_0001);
        run("mulh_min_sq",  MULH,   32'h8000_0000,  32'h8000_0000, MUL_LAT, 32'h4000_0000);
        run("mulhu_max_sq", MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE);
        run("mulhsu_m1",    MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFF);
        run("mulhu_small",  MULHU,  32'h1234_5678,  32'h0000_0010, MUL_LAT, 32'h0000_0001);

        run("div_m7_2",     DIV,    32'hFFFF_FFF9,  32'd2,         DIV_LAT, 32'hFFFF_FFFD);
        run("rem_m7_2",     REM,    32'hFFFF_FFF9,  32'd2,         DIV_LAT, 32'hFFFF_FFFF);
        run("divu_100_7",   DIVU,   32'd100,        32'd7,         DIV_LAT, 32'd14);
        run("remu_100_7",   REMU,   32'd100,        32'd7,         DIV_LAT, 32'd2);
        run("div_20_m6",    DIV,    32'd20,         32'hFFFF_FFFA, DIV_LAT, 32'hFFFF_FFFD);
        run("rem_20_m6",    REM,    32'd20,         32'hFFFF_FFFA, DIV_LAT, 32'd2);
        run("divu_max_1",   DIVU,   32'hFFFF_FFFF,  32'd1,         DIV_LAT, 32'hFFFF_FFFF);
        run("remu_max_16",  REMU,   32'hFFFF_FFFF,  32'd16,        DIV_LAT, 32'd15);
        run("divu_big_dsr", DIVU,   32'hFFFF_FFFF,  32'h8000_0001, DIV_LAT, 32'd1);

        run("div_5_0",      DIV,    32'd5,          32'd0,         SPC_LAT, 32'hFFFF_FFFF);
        run("rem_5_0",      REM,    32'd5,          32'd0,         SPC_LAT, 32'd5);
        run("divu_5_0",     DIVU,   32'd5,          32'd0,         SPC_LAT, 32'hFFFF_FFFF);
        run("remu_9_0",     REMU,   32'd9,          32'd0,         SPC_LAT, 32'd9);
        run("div_ovf",      DIV,    32'h8000_0000,  32'hFFFF_FFFF, SPC_LAT, 32'h8000_0000);
        run("rem_ovf",      REM,    32'h8000_0000,  32'hFFFF_FFFF, SPC_LAT, 32'd0);

        // Backpressure: result held for 10 cycles with out_ready low.
        issue("bp", DIVU, 32'd100, 32'd7);
        wait_out("bp", DIV_LAT, 32'd14);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid",    {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_result",   bus.Result,             32'd14);
            chk("bp_hold_in_ready", {31'd0, bus.in_ready},  32'd0);
            chk("bp_hold_busy",     {31'd0, bus.busy},      32'd1);
        end
        take("bp");
        run("bp_next", REMU, 32'd100, 32'd7, DIV_LAT, 32'd2);

        // kill together with in_valid in IDLE: nothing accepted.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.kill      = 1'b1;
        bus.Operation = DIVU;
        bus.SrcA      = 32'd100;
        bus.SrcB      = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        chk("kill_idle_busy",     {31'd0, bus.busy},     32'd0);
        chk("kill_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        watch_quiet("kill_idle_no_valid", 40);

        // kill in CALC cycle 10.
        issue("kcalc", DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        chk("kcalc_busy_before", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        chk("kcalc_busy_after",  {31'd0, bus.busy},      32'd0);
        chk("kcalc_valid_after", {31'd0, bus.out_valid}, 32'd0);
        watch_quiet("kcalc_no_valid", 40);

        // kill in DONE drops the untaken result.
        issue("kdone", REMU, 32'd9, 32'd0);
        wait_out("kdone", SPC_LAT, 32'd9);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        chk("kdone_valid_after", {31'd0, bus.out_valid}, 32'd0);
        chk("kdone_in_ready",    {31'd0, bus.in_ready},  32'd1);

        // Asynchronous reset in the middle of a divide.
        issue("rmid", DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rmid_result",    bus.Result,             32'd0);
        chk("rmid_busy",      {31'd0, bus.busy},      32'd0);
        chk("rmid_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("rmid_no_stale_valid", 40);
        run("rmid_next_rem", REM, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF);
        run("rmid_next_mul", MUL, 32'd7, 32'hFFFF_FFFD, MUL_LAT, 32'hFFFF_FFEB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
